// File: rtl/mm2_trap_ctrl_pkg.sv
// Shared definitions for the MM2 trap/ERTN commit controller: exception codes,
// opcodes, the exception-index-to-ecode table and FSM state encodings.
package mm2_trap_ctrl_pkg;

   localparam logic [5:0] ECODE_INT = 6'h00;
   localparam logic [5:0] ECODE_ADE = 6'h08;
   localparam logic [5:0] ECODE_ALE = 6'h09;
   localparam logic [5:0] ECODE_SYS = 6'h0b;
   localparam logic [5:0] ECODE_BRK = 6'h0c;
   localparam logic [5:0] ECODE_INE = 6'h0d;
   localparam logic [5:0] ECODE_IPE = 6'h0e;

   localparam logic [8:0] ESUB_NONE = 9'd0;
   localparam logic [8:0] ESUB_ADEM = 9'd1;

   localparam logic [7:0] OP_NOP     = 8'h00;
   localparam logic [7:0] OP_CSRWR   = 8'h10;
   localparam logic [7:0] OP_CSRXCHG = 8'h11;
   localparam logic [7:0] OP_CSRRD   = 8'h12;
   localparam logic [7:0] OP_ERTN    = 8'h20;

   // Exception flag index -> ecode; index 0 is the highest priority flag.
   localparam logic [5:0] EXC_ECODE [8] = '{
      ECODE_ADE, ECODE_INE, ECODE_ALE, ECODE_SYS,
      ECODE_BRK, ECODE_IPE, ECODE_IPE, ECODE_IPE
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COMMIT = 2'd1,
      ST_FLUSH  = 2'd2
   } trap_state_e;

   function automatic logic ecode_has_badv(input logic [5:0] ecode);
      return (ecode == ECODE_ADE) || (ecode == ECODE_ALE);
   endfunction

endpackage

// File: rtl/mm2_trap_ctrl_trap_int_sync.sv
// Multi-flop synchroniser for the asynchronous hardware interrupt lines.
module trap_int_sync
   import mm2_trap_ctrl_pkg::*;
#(
   parameter int NUM_HWI     = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [NUM_HWI-1:0] hw_int,
   output logic [NUM_HWI-1:0] hw_int_sync
);

   logic [NUM_HWI-1:0] stage_d [SYNC_STAGES];
   logic [NUM_HWI-1:0] stage_q [SYNC_STAGES];

   // Shift each line one stage deeper per clock.
   always_comb begin
      stage_d[0] = hw_int;
      for (int s = 1; s < SYNC_STAGES; s++) begin
         stage_d[s] = stage_q[s-1];
      end
   end

   // Synchroniser flops, cleared on reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            stage_q[s] <= '0;
         end
      end else begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            stage_q[s] <= stage_d[s];
         end
      end
   end

   assign hw_int_sync = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/mm2_trap_ctrl.sv
// MM2 exception/interrupt commit controller: arbitrates traps, gates CSR writes
// and sequences each trap or ERTN as COMMIT followed by FLUSH.
module mm2_trap_ctrl
   import mm2_trap_ctrl_pkg::*;
#(
   parameter int NUM_EXC      = 6,
   parameter int NUM_HWI      = 8,
   parameter int SYNC_STAGES  = 2,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               mm2_valid,
   input  logic [7:0]         mm2_op,
   input  logic [NUM_EXC-1:0] mm2_exc_vec,
   input  logic               mm2_adem,
   input  logic [31:0]        mm2_pc,
   input  logic [31:0]        mm2_vaddr,
   input  logic [NUM_HWI-1:0] hw_int,
   input  logic               csr_ie,
   input  logic [NUM_HWI-1:0] csr_lie,
   output logic               mm2_csr_we,
   output logic [5:0]         mm2_ecode,
   output logic [8:0]         mm2_esubcode,
   output logic               exc_commit,
   output logic [31:0]        exc_era,
   output logic               badv_we,
   output logic [31:0]        exc_badv,
   output logic               ertn_commit,
   output logic               pipe_flush,
   output logic               mm2_stall,
   output logic [NUM_HWI-1:0] int_pending
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   // Lowest set index wins; NUM_EXC is limited to the 8-entry ecode table.
   function automatic logic [2:0] exc_prio_idx(input logic [NUM_EXC-1:0] vec);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = NUM_EXC - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = i[2:0];
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   trap_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ertn_q, ertn_d;
   logic               badv_flag_q, badv_flag_d;
   logic [5:0]         ecode_q, ecode_d;
   logic [8:0]         esub_q, esub_d;
   logic [31:0]        era_q, era_d;
   logic [31:0]        badv_q, badv_d;
   logic               out_en_q;

   logic [NUM_HWI-1:0] hw_int_sync_s;
   logic               int_req_s;
   logic               trap_s;
   logic [2:0]         exc_idx_s;
   logic [5:0]         trap_ecode_s;
   logic [8:0]         trap_esub_s;
   logic               csr_we_s;

   trap_int_sync #(
      .NUM_HWI     (NUM_HWI),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_int_sync (
      .clk         (clk),
      .resetn      (resetn),
      .hw_int      (hw_int),
      .hw_int_sync (hw_int_sync_s)
   );

   assign int_pending = hw_int_sync_s & csr_lie;

   // Trap arbitration and next-state logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ertn_d       = ertn_q;
      badv_flag_d  = badv_flag_q;
      ecode_d      = ecode_q;
      esub_d       = esub_q;
      era_d        = era_q;
      badv_d       = badv_q;
      csr_we_s     = 1'b0;

      int_req_s    = csr_ie & (|int_pending);
      trap_s       = mm2_valid & ((|mm2_exc_vec) | int_req_s);
      exc_idx_s    = exc_prio_idx(mm2_exc_vec);
      trap_ecode_s = int_req_s ? ECODE_INT : EXC_ECODE[exc_idx_s];
      if (!int_req_s && (trap_ecode_s == ECODE_ADE) && mm2_adem) begin
         trap_esub_s = ESUB_ADEM;
      end else begin
         trap_esub_s = ESUB_NONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (trap_s) begin
               state_d     = ST_COMMIT;
               ertn_d      = 1'b0;
               badv_flag_d = !int_req_s && ecode_has_badv(trap_ecode_s);
               ecode_d     = trap_ecode_s;
               esub_d      = trap_esub_s;
               era_d       = mm2_pc;
               badv_d      = mm2_vaddr;
            end else if (mm2_valid && (mm2_op == OP_ERTN)) begin
               state_d     = ST_COMMIT;
               ertn_d      = 1'b1;
               badv_flag_d = 1'b0;
            end else begin
               csr_we_s = out_en_q & mm2_valid &
                          ((mm2_op == OP_CSRWR) || (mm2_op == OP_CSRXCHG));
            end
         end
         ST_COMMIT: begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
         end
         ST_FLUSH: begin
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, flush counter and latched trap record.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         ertn_q      <= 1'b0;
         badv_flag_q <= 1'b0;
         ecode_q     <= 6'd0;
         esub_q      <= 9'd0;
         era_q       <= 32'd0;
         badv_q      <= 32'd0;
         out_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ertn_q      <= ertn_d;
         badv_flag_q <= badv_flag_d;
         ecode_q     <= ecode_d;
         esub_q      <= esub_d;
         era_q       <= era_d;
         badv_q      <= badv_d;
         out_en_q    <= 1'b1;
      end
   end

   // Strobes decode straight from flops so reset kills them asynchronously.
   assign exc_commit   = (state_q == ST_COMMIT) & ~ertn_q;
   assign ertn_commit  = (state_q == ST_COMMIT) & ertn_q;
   assign badv_we      = (state_q == ST_COMMIT) & ~ertn_q & badv_flag_q;
   assign pipe_flush   = (state_q != ST_IDLE);
   assign mm2_stall    = (state_q != ST_IDLE);
   assign mm2_csr_we   = csr_we_s;
   assign mm2_ecode    = ecode_q;
   assign mm2_esubcode = esub_q;
   assign exc_era      = era_q;
   assign exc_badv     = badv_q;

endmodule

// File: tb/tb_mm2_trap_ctrl.sv
// Directed self-checking bench for mm2_trap_ctrl with a commit scoreboard.
module tb_mm2_trap_ctrl;
   import mm2_trap_ctrl_pkg::*;

   localparam int NUM_EXC = 6;
   localparam int NUM_HWI = 8;

   logic               clk = 1'b0;
   logic               resetn;
   logic               mm2_valid;
   logic [7:0]         mm2_op;
   logic [NUM_EXC-1:0] mm2_exc_vec;
   logic               mm2_adem;
   logic [31:0]        mm2_pc;
   logic [31:0]        mm2_vaddr;
   logic [NUM_HWI-1:0] hw_int;
   logic               csr_ie;
   logic [NUM_HWI-1:0] csr_lie;
   logic               mm2_csr_we;
   logic [5:0]         mm2_ecode;
   logic [8:0]         mm2_esubcode;
   logic               exc_commit;
   logic [31:0]        exc_era;
   logic               badv_we;
   logic [31:0]        exc_badv;
   logic               ertn_commit;
   logic               pipe_flush;
   logic               mm2_stall;
   logic [NUM_HWI-1:0] int_pending;

   typedef struct {
      logic        is_ertn;
      logic [5:0]  ecode;
      logic [8:0]  esub;
      logic [31:0] era;
      logic [31:0] badv;
      logic        badv_we;
   } exp_t;

   exp_t sb_q[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   int   fail_cnt = 0;

   mm2_trap_ctrl #(
      .NUM_EXC      (NUM_EXC),
      .NUM_HWI      (NUM_HWI),
      .SYNC_STAGES  (2),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .mm2_valid    (mm2_valid),
      .mm2_op       (mm2_op),
      .mm2_exc_vec  (mm2_exc_vec),
      .mm2_adem     (mm2_adem),
      .mm2_pc       (mm2_pc),
      .mm2_vaddr    (mm2_vaddr),
      .hw_int       (hw_int),
      .csr_ie       (csr_ie),
      .csr_lie      (csr_lie),
      .mm2_csr_we   (mm2_csr_we),
      .mm2_ecode    (mm2_ecode),
      .mm2_esubcode (mm2_esubcode),
      .exc_commit   (exc_commit),
      .exc_era      (exc_era),
      .badv_we      (badv_we),
      .exc_badv     (exc_badv),
      .ertn_commit  (ertn_commit),
      .pipe_flush   (pipe_flush),
      .mm2_stall    (mm2_stall),
      .int_pending  (int_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      chk_cnt++;
      assert (obs === exp_v) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic issue(input logic [7:0] op, input logic [NUM_EXC-1:0] exc,
                        input logic adem, input logic [31:0] pc, input logic [31:0] va);
      @(negedge clk);
      mm2_valid   = 1'b1;
      mm2_op      = op;
      mm2_exc_vec = exc;
      mm2_adem    = adem;
      mm2_pc      = pc;
      mm2_vaddr   = va;
   endtask

   task automatic push_exp(input logic is_ertn, input logic [5:0] ec, input logic [8:0] es,
                           input logic [31:0] era, input logic [31:0] bv, input logic bwe);
      exp_t e;
      e.is_ertn = is_ertn;
      e.ecode   = ec;
      e.esub    = es;
      e.era     = era;
      e.badv    = bv;
      e.badv_we = bwe;
      sb_q.push_back(e);
   endtask

   task automatic expect_commit(input string tag);
      exp_t e;
      int   seen    = 0;
      int   flush_n = 0;
      int   stall_n = 0;
      int   strobes = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 0) begin
            mm2_valid   = 1'b0;
            mm2_exc_vec = '0;
            mm2_op      = OP_NOP;
         end
         if (exc_commit || ertn_commit) begin
            seen = 1;
            break;
         end
      end
      chk({tag, ":seen"}, 32'(seen), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, ":exc_commit"}, 32'(exc_commit), 32'(!e.is_ertn));
         chk({tag, ":ertn_commit"}, 32'(ertn_commit), 32'(e.is_ertn));
         chk({tag, ":badv_we"}, 32'(badv_we), 32'(e.badv_we));
         chk({tag, ":csr_we"}, 32'(mm2_csr_we), 32'd0);
         if (!e.is_ertn) begin
            chk({tag, ":ecode"}, 32'(mm2_ecode), 32'(e.ecode));
            chk({tag, ":esub"}, 32'(mm2_esubcode), 32'(e.esub));
            chk({tag, ":era"}, exc_era, e.era);
            if (e.badv_we) begin
               chk({tag, ":badv"}, exc_badv, e.badv);
            end
         end
      end else begin
         chk({tag, ":sb_nonempty"}, 32'd0, 32'd1);
      end
      flush_n = int'(pipe_flush);
      stall_n = int'(mm2_stall);
      strobes = int'(exc_commit | ertn_commit);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         flush_n += int'(pipe_flush);
         stall_n += int'(mm2_stall);
         strobes += int'(exc_commit | ertn_commit);
      end
      chk({tag, ":flush_len"}, 32'(flush_n), 32'd3);
      chk({tag, ":stall_len"}, 32'(stall_n), 32'd3);
      chk({tag, ":strobe_len"}, 32'(strobes), 32'd1);
   endtask

   initial begin
      int strobes;
      resetn      = 1'b0;
      mm2_valid   = 1'b0;
      mm2_op      = OP_NOP;
      mm2_exc_vec = '0;
      mm2_adem    = 1'b0;
      mm2_pc      = 32'd0;
      mm2_vaddr   = 32'd0;
      hw_int      = '0;
      csr_ie      = 1'b0;
      csr_lie     = '0;

      // reset state
      #12;
      chk("rst:flush", 32'(pipe_flush), 32'd0);
      chk("rst:stall", 32'(mm2_stall), 32'd0);
      chk("rst:strobes", 32'({exc_commit, ertn_commit, badv_we, mm2_csr_we}), 32'd0);
      chk("rst:ecode", 32'({mm2_ecode, mm2_esubcode}), 32'd0);
      chk("rst:era", exc_era, 32'd0);
      chk("rst:int_pending", 32'(int_pending), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // 1: CSR write gating
      mm2_valid = 1'b1;
      mm2_op    = OP_CSRWR;
      #1;
      chk("csrwr:we", 32'(mm2_csr_we), 32'd1);
      chk("csrwr:stall", 32'(mm2_stall), 32'd0);
      @(negedge clk);
      chk("csrwr:flush", 32'(pipe_flush), 32'd0);
      chk("csrwr:commit", 32'(exc_commit | ertn_commit), 32'd0);
      mm2_op = OP_CSRRD;
      #1;
      chk("csrrd:we", 32'(mm2_csr_we), 32'd0);
      mm2_valid = 1'b0;
      mm2_op    = OP_CSRXCHG;
      #1;
      chk("csr_invalid:we", 32'(mm2_csr_we), 32'd0);
      issue(OP_CSRXCHG, 6'b000010, 1'b0, 32'h1c000050, 32'h0);
      #1;
      chk("csrxchg_trap:we", 32'(mm2_csr_we), 32'd0);
      push_exp(1'b0, ECODE_INE, 9'd0, 32'h1c000050, 32'h0, 1'b0);
      expect_commit("csrxchg_trap");

      // 2: ALE wins over SYS
      issue(OP_NOP, 6'b001100, 1'b0, 32'h1c000100, 32'h3);
      push_exp(1'b0, ECODE_ALE, 9'd0, 32'h1c000100, 32'h3, 1'b1);
      expect_commit("ale");

      // 5: ADE subcode
      issue(OP_NOP, 6'b100001, 1'b1, 32'h1c000110, 32'h1c0000ff);
      push_exp(1'b0, ECODE_ADE, 9'd1, 32'h1c000110, 32'h1c0000ff, 1'b1);
      expect_commit("adem");
      issue(OP_NOP, 6'b000001, 1'b0, 32'h1c000120, 32'h80000001);
      push_exp(1'b0, ECODE_ADE, 9'd0, 32'h1c000120, 32'h80000001, 1'b1);
      expect_commit("adef");

      // 4: ERTN
      issue(OP_ERTN, 6'b000000, 1'b0, 32'h1c000130, 32'h0);
      push_exp(1'b1, 6'd0, 9'd0, 32'h0, 32'h0, 1'b0);
      expect_commit("ertn");
      chk("ertn:ecode_held", 32'(mm2_ecode), 32'(ECODE_ADE));
      issue(OP_ERTN, 6'b000001, 1'b0, 32'h1c000140, 32'h55);
      push_exp(1'b0, ECODE_ADE, 9'd0, 32'h1c000140, 32'h55, 1'b1);
      expect_commit("ertn_exc");

      // 3: interrupt through the synchroniser
      @(negedge clk);
      hw_int  = 8'h05;
      csr_lie = 8'h04;
      csr_ie  = 1'b1;
      @(negedge clk);
      chk("int:sync1", 32'(int_pending), 32'd0);
      @(negedge clk);
      chk("int:sync2", 32'(int_pending), 32'h04);
      csr_ie    = 1'b0;
      mm2_valid = 1'b1;
      mm2_op    = OP_CSRWR;
      #1;
      chk("int_masked:we", 32'(mm2_csr_we), 32'd1);
      @(negedge clk);
      chk("int_masked:flush", 32'(pipe_flush), 32'd0);
      mm2_valid = 1'b0;
      csr_ie    = 1'b1;
      issue(OP_NOP, 6'b001000, 1'b0, 32'h1c000200, 32'h77);
      push_exp(1'b0, ECODE_INT, 9'd0, 32'h1c000200, 32'h77, 1'b0);
      expect_commit("int");
      @(negedge clk);
      hw_int = 8'h00;
      @(negedge clk);
      @(negedge clk);
      chk("int:level_drop", 32'(int_pending), 32'd0);

      // 6: reset during FLUSH
      issue(OP_NOP, 6'b000100, 1'b0, 32'h1c000300, 32'h44);
      @(negedge clk);
      mm2_valid = 1'b0;
      chk("rstflush:commit", 32'(exc_commit), 32'd1);
      @(negedge clk);
      chk("rstflush:in_flush", 32'(pipe_flush), 32'd1);
      resetn = 1'b0;
      #1;
      chk("rstflush:flush", 32'(pipe_flush), 32'd0);
      chk("rstflush:stall", 32'(mm2_stall), 32'd0);
      chk("rstflush:ecode", 32'(mm2_ecode), 32'd0);
      chk("rstflush:era", exc_era, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      chk("rstflush:idle", 32'(pipe_flush), 32'd0);

      // 6: exceptions during COMMIT/FLUSH are ignored
      issue(OP_NOP, 6'b001000, 1'b0, 32'h1c000400, 32'h0);
      @(negedge clk);
      chk("nest:commit", 32'(exc_commit), 32'd1);
      chk("nest:ecode", 32'(mm2_ecode), 32'(ECODE_SYS));
      mm2_exc_vec = 6'b000100;
      mm2_pc      = 32'h1c000404;
      @(negedge clk);
      chk("nest:flush1", 32'(pipe_flush), 32'd1);
      @(negedge clk);
      chk("nest:flush2", 32'(pipe_flush), 32'd1);
      mm2_valid   = 1'b0;
      mm2_exc_vec = '0;
      strobes = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         strobes += int'(exc_commit | ertn_commit | badv_we);
      end
      chk("nest:no_commit", 32'(strobes), 32'd0);
      chk("nest:ecode_held", 32'(mm2_ecode), 32'(ECODE_SYS));
      chk("nest:era_held", exc_era, 32'h1c000400);
      chk("nest:sb_drained", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
